fft_out_reorder: RTL and testbench
==================================

Name: fft_out_reorder

Overview:
- Output-side reorder buffer for the 16-point radix-4 FFT.
- The butterfly datapath emits results in radix-4 digit-reversed order. This block accepts them one complex sample per cycle and re-emits each frame in natural bin order (X[0]..X[15]).
- Ping-pong storage of two 16-entry banks: one frame can be written while the previous frame drains, sustaining 1 sample/cycle.

Parameters:
- DATA_W, 16, signed width of each real/imaginary component. Matches the butterfly's 16-bit outputs.
- N, 16, frame length. Fixed: only 16 is legal (two base-4 digits). Elaboration error otherwise.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  buffer can accept a sample.
- in_re  in  DATA_W  signed real part, digit-reversed order.
- in_im  in  DATA_W  signed imaginary part.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts the sample.
- out_re  out  DATA_W  signed real part, natural order.
- out_im  out  DATA_W  signed imaginary part.
- out_idx  out  4  bin index of the current output sample.
- out_last  out  1  high with bin 15.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - wr_cnt=0, rd_cnt=0, wr_bank=0, rd_bank=0, bank_full=2'b00.
  - Outputs: in_ready=1, out_valid=0, out_re=0, out_im=0, out_idx=0, out_last=0.
  - Storage array is not reset.
  - Reset mid-frame discards all partial and complete frames.
- Write side:
  - A sample is accepted when in_valid && in_ready.
  - in_ready = !bank_full[wr_bank].
  - The k-th accepted sample (k = wr_cnt = 4a+b) is stored at address 4b+a, i.e. {wr_cnt[1:0], wr_cnt[3:2]}.
  - On acceptance, wr_cnt increments.
  - On accepting k=15: wr_cnt wraps to 0, bank_full[wr_bank] is set, and wr_bank toggles.
- Read side:
  - out_valid = bank_full[rd_bank].
  - out_re/out_im = mem[rd_bank][rd_cnt] (combinational read). Both are forced to 0 when out_valid=0.
  - out_idx = rd_cnt.
  - out_last = out_valid && rd_cnt==15.
  - On out_valid && out_ready: rd_cnt increments.
  - When rd_cnt==15 is accepted: rd_cnt wraps to 0, bank_full[rd_bank] is cleared, and rd_bank toggles.
  - out_re/out_im/out_idx are held stable while out_valid && !out_ready.
- Latency: out_valid rises the cycle after the 16th sample of a frame is accepted, provided rd_bank points at that bank.
- Throughput: 1 sample/cycle continuous when out_ready is held at 1.
- Full: both banks full -> in_ready=0. The cycle after the last read of the drained bank, in_ready=1.
- Simultaneous events:
  - Completing a write into one bank and completing a read from the other bank in the same cycle update both bank_full bits independently.
  - A bank can never be written and read concurrently (write needs !full, read needs full).
- No arithmetic is performed; data passes bit-exact.

Optional Feature:
- Macro: FFT_OUT_REORDER_BYPASS_EN.
- Defined:
  - Adds input port bypass (1 bit), sampled with the first accepted sample of each frame (wr_cnt==0) and held in a per-bank flag.
  - A frame with flag=1 is written at address wr_cnt (natural order, no reversal).
  - All handshake and timing behaviour is unchanged.
- Undefined: no bypass port; every frame is digit-reversed.

Decomposition:
- Shared package fft_pkg holds:
  - FFT_N=16, FFT_DATA_W=16.
  - typedef cplx_t {signed re, signed im}.
  - Function digit_rev4(idx[3:0]) -> {idx[1:0], idx[3:2]}. Also reused by the input-side stage and testbenches.
- One natural sub-module: fft_reorder_bank, a 16-entry complex register file with one write port and one combinational read port. Instantiated twice.

Test Plan:
- Single frame: feed in_re=k, in_im=-k for k=0..15 with out_ready=1 -> outputs on bins n=0..15 carry out_re=digit_rev4(n), e.g. bin1=4, bin4=1, bin6=9; out_last only on bin 15; out_valid rises 1 cycle after the 16th input.
- Back-to-back: 4 frames streamed continuously with out_ready=1 -> in_ready never drops, 64 outputs in correct order, no gaps after the first 17-cycle latency.
- Backpressure: out_ready=0 while 2 frames are written -> in_ready=0 after 32 accepts. Raise out_ready -> in_ready returns 1 the cycle after bin 15 of frame 0 is read. Data held stable during stall.
- Random valid/ready: random in_valid and out_ready at 50% over 100 frames -> scoreboard matches digit-reversed permutation, no loss or duplication.
- Reset mid-operation: assert rst_n=0 after 7 samples of frame 1 while frame 0 drains at bin 5 -> all outputs zero, in_ready=1. A fresh frame afterwards emerges correctly from bin 0.
- FFT_OUT_REORDER_BYPASS_EN: frame with bypass=1 followed by frame with bypass=0 -> first frame out_re=0..15 in order, second frame digit-reversed.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared definitions for the 16-point radix-4 FFT: frame size, sample width,
// complex sample type and the base-4 digit-reversal helper.
package fft_pkg;

    localparam int FFT_N      = 16;
    localparam int FFT_DATA_W = 16;

    typedef struct packed {
        logic signed [FFT_DATA_W-1:0] re;
        logic signed [FFT_DATA_W-1:0] im;
    } cplx_t;

    // Swap the two base-4 digits of a 4-bit index: 4a+b -> 4b+a.
    function automatic logic [3:0] digit_rev4(input logic [3:0] idx);
        return {idx[1:0], idx[3:2]};
    endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// 16-entry complex register file: one synchronous write port and one
// combinational read port. Contents are intentionally not reset.
module fft_reorder_bank
    import fft_pkg::*;
#(
    parameter int DATA_W = FFT_DATA_W,
    parameter int DEPTH  = FFT_N
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic signed [DATA_W-1:0]   wr_re,
    input  logic signed [DATA_W-1:0]   wr_im,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output logic signed [DATA_W-1:0]   rd_re,
    output logic signed [DATA_W-1:0]   rd_im
);

    logic signed [DATA_W-1:0] mem_re_q [DEPTH];
    logic signed [DATA_W-1:0] mem_re_d [DEPTH];
    logic signed [DATA_W-1:0] mem_im_q [DEPTH];
    logic signed [DATA_W-1:0] mem_im_d [DEPTH];

    always_comb begin
        mem_re_d = mem_re_q;
        mem_im_d = mem_im_q;
        if (we) begin
            mem_re_d[waddr] = wr_re;
            mem_im_d[waddr] = wr_im;
        end
    end

    always_ff @(posedge clk) begin
        mem_re_q <= mem_re_d;
        mem_im_q <= mem_im_d;
    end

    assign rd_re = mem_re_q[raddr];
    assign rd_im = mem_im_q[raddr];

endmodule

// File: rtl/fft_out_reorder.sv
// Ping-pong reorder buffer turning digit-reversed FFT output into natural bin
// order. Optional per-frame natural-order bypass: FFT_OUT_REORDER_BYPASS_EN.
module fft_out_reorder
    import fft_pkg::*;
#(
    parameter int DATA_W = FFT_DATA_W,
    parameter int N      = FFT_N
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [DATA_W-1:0]  in_re,
    input  logic signed [DATA_W-1:0]  in_im,
`ifdef FFT_OUT_REORDER_BYPASS_EN
    input  logic                      bypass,
`endif
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [DATA_W-1:0]  out_re,
    output logic signed [DATA_W-1:0]  out_im,
    output logic [3:0]                out_idx,
    output logic                      out_last
);

    generate
        if (N != 16) begin : g_bad_n
            $error("fft_out_reorder: N must be 16 (two base-4 digits)");
        end
    endgenerate

    logic [3:0] wr_cnt_q, wr_cnt_d;
    logic [3:0] rd_cnt_q, rd_cnt_d;
    logic       wr_bank_q, wr_bank_d;
    logic       rd_bank_q, rd_bank_d;
    logic [1:0] bank_full_q, bank_full_d;

    logic       in_fire, out_fire, wr_last, rd_last;
    logic [3:0] wr_addr;
    logic [1:0] bank_we;
    logic signed [DATA_W-1:0] bank_rd_re [2];
    logic signed [DATA_W-1:0] bank_rd_im [2];

`ifdef FFT_OUT_REORDER_BYPASS_EN
    logic [1:0] byp_flag_q, byp_flag_d;
`endif

    always_comb begin
        in_ready  = !bank_full_q[wr_bank_q];
        out_valid = bank_full_q[rd_bank_q];
        in_fire   = in_valid && in_ready;
        out_fire  = out_valid && out_ready;
        wr_last   = in_fire && (wr_cnt_q == 4'd15);
        rd_last   = out_fire && (rd_cnt_q == 4'd15);

        wr_cnt_d  = in_fire  ? wr_cnt_q + 4'd1 : wr_cnt_q;
        rd_cnt_d  = out_fire ? rd_cnt_q + 4'd1 : rd_cnt_q;
        wr_bank_d = wr_bank_q ^ wr_last;
        rd_bank_d = rd_bank_q ^ rd_last;

        // Write and read always target different banks, so both updates can land together.
        bank_full_d = bank_full_q;
        if (wr_last) bank_full_d[wr_bank_q] = 1'b1;
        if (rd_last) bank_full_d[rd_bank_q] = 1'b0;

        bank_we = 2'b00;
        if (in_fire) bank_we[wr_bank_q] = 1'b1;

`ifdef FFT_OUT_REORDER_BYPASS_EN
        byp_flag_d = byp_flag_q;
        if (in_fire && (wr_cnt_q == 4'd0)) byp_flag_d[wr_bank_q] = bypass;
        // Sample 0 lands at address 0 in either order, so the stale flag is harmless there.
        wr_addr = byp_flag_q[wr_bank_q] ? wr_cnt_q : digit_rev4(wr_cnt_q);
`else
        wr_addr = digit_rev4(wr_cnt_q);
`endif

        out_re   = out_valid ? bank_rd_re[rd_bank_q] : '0;
        out_im   = out_valid ? bank_rd_im[rd_bank_q] : '0;
        out_idx  = rd_cnt_q;
        out_last = out_valid && (rd_cnt_q == 4'd15);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_q    <= 4'd0;
            rd_cnt_q    <= 4'd0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            bank_full_q <= 2'b00;
`ifdef FFT_OUT_REORDER_BYPASS_EN
            byp_flag_q  <= 2'b00;
`endif
        end else begin
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            bank_full_q <= bank_full_d;
`ifdef FFT_OUT_REORDER_BYPASS_EN
            byp_flag_q  <= byp_flag_d;
`endif
        end
    end

    generate
        for (genvar g = 0; g < 2; g++) begin : g_bank
            fft_reorder_bank #(
                .DATA_W (DATA_W),
                .DEPTH  (16)
            ) u_bank (
                .clk   (clk),
                .we    (bank_we[g]),
                .waddr (wr_addr),
                .wr_re (in_re),
                .wr_im (in_im),
                .raddr (rd_cnt_q),
                .rd_re (bank_rd_re[g]),
                .rd_im (bank_rd_im[g])
            );
        end
    endgenerate

endmodule

// File: tb/tb_fft_out_reorder.sv
// Directed and random bench for fft_out_reorder with a frame-level scoreboard.
module tb_fft_out_reorder;

    localparam int W = 16;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] in_re;
    logic signed [W-1:0] in_im;
    logic                bypass;
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] out_re;
    logic signed [W-1:0] out_im;
    logic [3:0]          out_idx;
    logic                out_last;

    always #5 clk = ~clk;

    fft_out_reorder #(.DATA_W(W), .N(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
`ifdef FFT_OUT_REORDER_BYPASS_EN
        .bypass    (bypass),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    typedef struct {
        logic signed [W-1:0] re;
        logic signed [W-1:0] im;
        logic [3:0]          idx;
        logic                last;
    } exp_t;

    exp_t                sb[$];
    logic signed [W-1:0] fr_re [16];
    logic signed [W-1:0] fr_im [16];
    logic                fr_byp;
    int                  wcnt;
    int                  n_in;
    int                  n_out;
    int                  n_checks = 0;
    int                  n_fail   = 0;
    logic signed [W-1:0] last_re;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at the falling edge, check just after, then wait for the next falling edge.
    task automatic cyc(input logic iv, input logic signed [W-1:0] re,
                       input logic signed [W-1:0] im, input logic ordy);
        exp_t e;
        in_valid  = iv;
        in_re     = re;
        in_im     = im;
        out_ready = ordy;
        #1;
        if (out_valid) begin
            n_checks++;
            assert (sb.size() > 0) else begin
                n_fail++;
                $error("FAIL sb_underflow: observed out_valid=1 expected no output");
            end
            if (sb.size() > 0) begin
                e = sb[0];
                chk("out_re",   32'(out_re),   32'(e.re));
                chk("out_im",   32'(out_im),   32'(e.im));
                chk("out_idx",  32'(out_idx),  32'(e.idx));
                chk("out_last", 32'(out_last), 32'(e.last));
                if (ordy) begin
                    void'(sb.pop_front());
                    n_out++;
                    last_re = out_re;
                end
            end
        end else begin
            chk("idle_data", {out_re, out_im}, 32'h0);
            chk("idle_last", 32'(out_last), 32'h0);
        end
        if (iv && in_ready) begin
            if (wcnt == 0) fr_byp = bypass;
            fr_re[wcnt] = re;
            fr_im[wcnt] = im;
            wcnt++;
            n_in++;
            if (wcnt == 16) begin
                wcnt = 0;
                for (int n = 0; n < 16; n++) begin
                    int k;
                    k = fr_byp ? n : (n % 4) * 4 + n / 4;
                    e.re   = fr_re[k];
                    e.im   = fr_im[k];
                    e.idx  = 4'(n);
                    e.last = (n == 15);
                    sb.push_back(e);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        for (int c = 0; c < 40 && sb.size() > 0; c++) cyc(1'b0, '0, '0, 1'b1);
        chk(tag, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; bypass = 1'b0;
        in_re = '0; in_im = '0; wcnt = 0; n_in = 0; n_out = 0; fr_byp = 1'b0; last_re = '0;
        @(negedge clk);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  {out_re, out_im}, 32'd0);
        chk("rst_out_idx",   32'(out_idx),   32'd0);
        chk("rst_out_last",  32'(out_last),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single frame
        for (int k = 0; k < 16; k++) begin
            chk("single_early_valid", 32'(out_valid), 32'd0);
            cyc(1'b1, W'(k), W'(-k), 1'b1);
        end
        chk("single_latency", 32'(out_valid), 32'd1);
        for (int n = 0; n < 16; n++) begin
            cyc(1'b0, '0, '0, 1'b1);
            if (n == 1) chk("single_bin1", 32'(last_re), 32'd4);
            if (n == 4) chk("single_bin4", 32'(last_re), 32'd1);
            if (n == 6) chk("single_bin6", 32'(last_re), 32'd9);
        end
        chk("single_empty", 32'(sb.size()), 32'd0);
        chk("single_done_valid", 32'(out_valid), 32'd0);

        // Back-to-back, four frames
        n_out = 0;
        for (int i = 0; i < 80; i++) begin
            if (i < 64)  chk("b2b_in_ready", 32'(in_ready), 32'd1);
            if (i >= 16) chk("b2b_no_gap", 32'(out_valid), 32'd1);
            cyc(i < 64, W'(i * 3 + 100), W'(-i), 1'b1);
        end
        chk("b2b_count", 32'(n_out), 32'd64);
        drain("b2b_empty");

        // Backpressure
        for (int i = 0; i < 32; i++) begin
            chk("bp_accept", 32'(in_ready), 32'd1);
            cyc(1'b1, W'(1000 + i), W'(i), 1'b0);
        end
        chk("bp_full", 32'(in_ready), 32'd0);
        cyc(1'b1, W'(7777), W'(7), 1'b0);
        cyc(1'b1, W'(7777), W'(7), 1'b0);
        for (int i = 0; i < 16; i++) begin
            chk("bp_still_full", 32'(in_ready), 32'd0);
            cyc(1'b0, '0, '0, 1'b1);
        end
        chk("bp_release", 32'(in_ready), 32'd1);
        drain("bp_empty");

        // Random valid/ready, 100 frames
        n_in = 0; n_out = 0;
        for (int c = 0; c < 20000 && n_in < 1600; c++)
            cyc(1'($urandom % 2), W'($urandom), W'($urandom), 1'($urandom % 2));
        chk("rand_inputs", 32'(n_in), 32'd1600);
        drain("rand_empty");
        chk("rand_outputs", 32'(n_out), 32'd1600);

        // Reset mid-operation
        for (int i = 0; i < 16; i++) cyc(1'b1, W'(2000 + i), W'(-i), 1'b0);
        for (int i = 0; i < 7; i++)  cyc(1'b1, W'(3000 + i), W'(i), i < 5);
        chk("mid_bin", 32'(out_idx), 32'd5);
        in_valid = 1'b0; out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready",  32'(in_ready),  32'd1);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_data",      {out_re, out_im}, 32'd0);
        chk("mid_rst_idx",       32'(out_idx),   32'd0);
        chk("mid_rst_last",      32'(out_last),  32'd0);
        sb.delete(); wcnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 16; i++) cyc(1'b1, W'(4000 + i), W'(i * 2), 1'b0);
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        chk("post_rst_idx",   32'(out_idx),   32'd0);
        drain("post_rst_empty");

`ifdef FFT_OUT_REORDER_BYPASS_EN
        for (int i = 0; i < 16; i++) begin
            bypass = (i == 0);
            cyc(1'b1, W'(i), W'(-i), 1'b1);
        end
        for (int i = 0; i < 16; i++) begin
            bypass = 1'b0;
            cyc(1'b1, W'(i), W'(-i), 1'b1);
        end
        drain("bypass_empty");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
